// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache.
//   64 lines x 64 bits, indexed by doubleword address bits [5:0] with a 5-bit tag.
//   A read hit completes one cycle after accept. Read misses refill the line from
//   backing memory. Every write goes to memory, and the line is updated only on a hit.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   dcache_req_addr[11:0]      byte address bits [13:2]; bit 0 ignored
//   dcache_req_valid/_rw       request strobe (held until dcache_ready), 1 = write
//   dcache_data_write[63:0]    doubleword to write
//   dcache_data_read[63:0]     read data, held between completions
//   dcache_ready, dcache_hit   one-cycle completion pulse, hit qualifier
//   inv_i                      invalidate all lines (deferred until IDLE)
//   mem_req_valid/_rw/_addr    backing-memory request (doubleword address)
//   mem_wdata[63:0]            write data to memory
//   mem_rdata[63:0], mem_ack   memory read data and one-cycle completion pulse
module dcache (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] dcache_req_addr,
    input  logic        dcache_req_valid,
    input  logic        dcache_req_rw,
    input  logic [63:0] dcache_data_write,
    output logic [63:0] dcache_data_read,
    output logic        dcache_ready,
    output logic        dcache_hit,
    input  logic        inv_i,
    output logic        mem_req_valid,
    output logic        mem_req_rw,
    output logic [10:0] mem_req_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

    state_t      state_reg, state_next;
    logic [10:0] addr_reg;
    logic        rw_reg;
    logic [63:0] wdata_reg;
    logic        hit_reg;
    logic [63:0] refill_data_reg;
    logic [63:0] data_out_reg;
    logic        inv_pend_reg;
    logic [63:0] valid_vec;

    logic [4:0]  tag_mem  [64];
    logic [63:0] data_mem [64];
    logic [63:0] ram_q;

    logic [5:0]  req_index;
    logic [4:0]  req_tag;
    logic [5:0]  reg_index;
    logic [4:0]  reg_tag;
    logic        req_hit;
    logic        inv_now;
    logic        accept;
    logic        line_fill;
    logic        line_update;
    logic [63:0] resp_data;
    logic        unused_addr_bit;

    assign unused_addr_bit = dcache_req_addr[0];

    assign req_index = dcache_req_addr[6:1];
    assign req_tag   = dcache_req_addr[11:7];
    assign reg_index = addr_reg[5:0];
    assign reg_tag   = addr_reg[10:6];

    assign req_hit = valid_vec[req_index] && (tag_mem[req_index] == req_tag);

    // An invalidate (fresh or deferred) owns the IDLE cycle; no request is taken.
    assign inv_now     = (state_reg == IDLE) && (inv_i || inv_pend_reg);
    assign accept      = (state_reg == IDLE) && !inv_now && dcache_req_valid;
    assign line_fill   = (state_reg == REFILL) && mem_ack;
    assign line_update = (state_reg == WRITE) && mem_ack && hit_reg;

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = dcache_req_rw ? WRITE : (req_hit ? RESP : REFILL);
            REFILL:  if (mem_ack) state_next = RESP;
            WRITE:   if (mem_ack) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            rw_reg          <= 1'b0;
            wdata_reg       <= '0;
            hit_reg         <= 1'b0;
            refill_data_reg <= '0;
            data_out_reg    <= '0;
            inv_pend_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg  <= dcache_req_addr[11:1];
                rw_reg    <= dcache_req_rw;
                wdata_reg <= dcache_data_write;
                hit_reg   <= req_hit;
            end
            if (line_fill) begin
                refill_data_reg <= mem_rdata;
            end
            // Capture what was presented during RESP so it is held afterwards.
            if (state_reg == RESP) begin
                data_out_reg <= resp_data;
            end
            if (inv_now) begin
                inv_pend_reg <= 1'b0;
            end else if (inv_i && (state_reg != IDLE)) begin
                inv_pend_reg <= 1'b1;
            end
        end
    end

    // Per-line valid bits: cleared by reset or invalidate, set by a refill.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : gen_valid
            logic line_valid_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    line_valid_reg <= 1'b0;
                end else if (inv_now) begin
                    line_valid_reg <= 1'b0;
                end else if (line_fill && (reg_index == 6'(gi))) begin
                    line_valid_reg <= 1'b1;
                end
            end
            assign valid_vec[gi] = line_valid_reg;
        end
    endgenerate

    // Line storage. The data array uses a registered read at accept, so a hit's
    // data is available in the RESP cycle. The tag array is read at accept for the hit test.
    always_ff @(posedge clk) begin
        if (accept) begin
            ram_q <= data_mem[req_index];
        end
        if (line_fill) begin
            data_mem[reg_index] <= mem_rdata;
            tag_mem[reg_index]  <= reg_tag;
        end else if (line_update) begin
            data_mem[reg_index] <= wdata_reg;
        end
    end

    // A write completion leaves the previously returned read data in place.
    assign resp_data = rw_reg ? data_out_reg : (hit_reg ? ram_q : refill_data_reg);

    assign dcache_data_read = (state_reg == RESP) ? resp_data : data_out_reg;
    assign dcache_ready     = (state_reg == RESP);
    assign dcache_hit       = (state_reg == RESP) && hit_reg;

    assign mem_req_valid = (state_reg == REFILL) || (state_reg == WRITE);
    assign mem_req_rw    = (state_reg == WRITE);
    assign mem_req_addr  = addr_reg;
    assign mem_wdata     = wdata_reg;

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: self-checking bench for dcache. It contains a backing-memory responder,
// a table of directed vectors, hand-written reset/invalidate sequences, and randomized
// traffic. The randomized traffic is checked against a line-residency and memory model.
module tb_dcache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] dcache_req_addr;
    logic        dcache_req_valid;
    logic        dcache_req_rw;
    logic [63:0] dcache_data_write;
    logic [63:0] dcache_data_read;
    logic        dcache_ready;
    logic        dcache_hit;
    logic        inv_i;
    logic        mem_req_valid;
    logic        mem_req_rw;
    logic [10:0] mem_req_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    dcache dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dcache_req_addr   (dcache_req_addr),
        .dcache_req_valid  (dcache_req_valid),
        .dcache_req_rw     (dcache_req_rw),
        .dcache_data_write (dcache_data_write),
        .dcache_data_read  (dcache_data_read),
        .dcache_ready      (dcache_ready),
        .dcache_hit        (dcache_hit),
        .inv_i             (inv_i),
        .mem_req_valid     (mem_req_valid),
        .mem_req_rw        (mem_req_rw),
        .mem_req_addr      (mem_req_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: backing memory plus which tag (if any) each line holds.
    // In a write-through cache, a resident line always mirrors memory.
    logic [63:0] mem_model [2048];
    logic        m_valid   [64];
    logic [4:0]  m_tag     [64];

    typedef struct {
        logic        got;
        logic        hit;
        logic [63:0] data;
        int          cycles;
        logic        saw_mem;
        logic        mem_ok;
    } res_t;

    typedef struct {
        logic        rw;
        logic [11:0] addr;
        logic [63:0] wdata;
        int          lat;
        logic        exp_hit;
        logic [63:0] exp_data;
        logic        exp_mem;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    // Issue one request, act as backing memory (ack after 'lat' request cycles),
    // and optionally pulse inv_i on cycle inv_at. Returns when the cache is back in IDLE.
    task automatic run_req(input logic rw, input logic [11:0] addr, input logic [63:0] wd,
                           input int lat, input int inv_at, output res_t r);
        logic [10:0] dw;
        int mem_cyc;
        int cyc;
        dw        = addr[11:1];
        r.got     = 1'b0;
        r.hit     = 1'b0;
        r.data    = '0;
        r.cycles  = 0;
        r.saw_mem = 1'b0;
        r.mem_ok  = 1'b1;
        mem_cyc   = 0;
        cyc       = 0;
        dcache_req_valid  = 1'b1;
        dcache_req_rw     = rw;
        dcache_req_addr   = addr;
        dcache_data_write = wd;
        while (!r.got && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            mem_ack = 1'b0;
            inv_i   = (cyc == inv_at);
            if (dcache_ready) begin
                r.got    = 1'b1;
                r.hit    = dcache_hit;
                r.data   = dcache_data_read;
                r.cycles = cyc;
                dcache_req_valid = 1'b0;
            end else if (mem_req_valid) begin
                r.saw_mem = 1'b1;
                if (mem_req_rw !== rw || mem_req_addr !== dw || (rw && mem_wdata !== wd))
                    r.mem_ok = 1'b0;
                mem_cyc++;
                if (mem_cyc == lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_model[dw];
                    if (rw) mem_model[dw] = wd;
                end
            end
        end
        inv_i = 1'b0;
        mem_ack = 1'b0;
        dcache_req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Request checked against the model; the model is updated afterwards.
    task automatic model_req(input logic rw, input logic [11:0] addr, input logic [63:0] wd,
                             input int lat, input string nm);
        res_t r;
        logic [10:0] dw;
        logic [5:0]  idx;
        logic        eh;
        logic [63:0] ed;
        dw  = addr[11:1];
        idx = dw[5:0];
        eh  = m_valid[idx] && (m_tag[idx] == dw[10:6]);
        ed  = mem_model[dw];
        run_req(rw, addr, wd, lat, 0, r);
        $display("%s: rw=%0d addr=%h hit=%0d data=%h cycles=%0d", nm, rw, addr, r.hit, r.data, r.cycles);
        chk({nm, ".ready"}, 64'(r.got), 64'(1));
        if (r.got) begin
            chk({nm, ".hit"}, 64'(r.hit), 64'(eh));
            if (!rw) chk({nm, ".data"}, r.data, ed);
            chk({nm, ".mem_used"}, 64'(r.saw_mem), 64'(rw || !eh));
            chk({nm, ".mem_fields"}, 64'(r.mem_ok), 64'(1));
            if (!rw && eh) chk({nm, ".latency"}, 64'(r.cycles), 64'(1));
        end
        if (!rw && !eh) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = dw[10:6];
        end
    endtask

    vec_t tbl [9];

    initial begin
        res_t        r;
        logic [11:0] ra;
        logic [63:0] rd;
        logic        rrw;

        tbl[0] = '{1'b0, 12'h010, 64'h0, 3, 1'b0, 64'hDEADBEEF_01234567, 1'b1};
        tbl[1] = '{1'b0, 12'h010, 64'h0, 3, 1'b1, 64'hDEADBEEF_01234567, 1'b0};
        tbl[2] = '{1'b1, 12'h010, 64'h1, 2, 1'b1, 64'h0,                 1'b1};
        tbl[3] = '{1'b0, 12'h010, 64'h0, 2, 1'b1, 64'h1,                 1'b0};
        tbl[4] = '{1'b1, 12'h800, 64'h5, 1, 1'b0, 64'h0,                 1'b1};
        tbl[5] = '{1'b0, 12'h800, 64'h0, 2, 1'b0, 64'h5,                 1'b1};
        tbl[6] = '{1'b0, 12'h090, 64'h0, 4, 1'b0, 64'hCAFE0000_00000090, 1'b1};
        tbl[7] = '{1'b0, 12'h010, 64'h0, 1, 1'b0, 64'h1,                 1'b1};
        tbl[8] = '{1'b0, 12'h010, 64'h0, 1, 1'b1, 64'h1,                 1'b0};

        for (int i = 0; i < 2048; i++) mem_model[i] = {$urandom, $urandom};
        mem_model[11'h008] = 64'hDEADBEEF_01234567;
        mem_model[11'h048] = 64'hCAFE0000_00000090;
        model_clear();

        rst_n = 1'b0;
        dcache_req_addr = '0; dcache_req_valid = 1'b0; dcache_req_rw = 1'b0;
        dcache_data_write = '0; inv_i = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("reset.ready", 64'(dcache_ready), 64'(0));
        chk("reset.hit", 64'(dcache_hit), 64'(0));
        chk("reset.data_read", dcache_data_read, 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: miss/hit, write hit, write miss, conflict.
        for (int i = 0; i < 9; i++) begin
            logic [10:0] dw;
            dw = tbl[i].addr[11:1];
            run_req(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].lat, 0, r);
            $display("vec%0d: rw=%0d addr=%h hit=%0d data=%h cycles=%0d", i, tbl[i].rw,
                     tbl[i].addr, r.hit, r.data, r.cycles);
            chk($sformatf("vec%0d.ready", i), 64'(r.got), 64'(1));
            chk($sformatf("vec%0d.hit", i), 64'(r.hit), 64'(tbl[i].exp_hit));
            if (!tbl[i].rw) chk($sformatf("vec%0d.data", i), r.data, tbl[i].exp_data);
            chk($sformatf("vec%0d.mem_used", i), 64'(r.saw_mem), 64'(tbl[i].exp_mem));
            chk($sformatf("vec%0d.mem_fields", i), 64'(r.mem_ok), 64'(1));
            if (!tbl[i].rw && tbl[i].exp_hit)
                chk($sformatf("vec%0d.latency", i), 64'(r.cycles), 64'(1));
            if (!tbl[i].rw && !(m_valid[dw[5:0]] && m_tag[dw[5:0]] == dw[10:6])) begin
                m_valid[dw[5:0]] = 1'b1;
                m_tag[dw[5:0]]   = dw[10:6];
            end
        end

        // Invalidate in IDLE: a resident line misses afterwards.
        inv_i = 1'b1;
        @(posedge clk); #1;
        inv_i = 1'b0;
        model_clear();
        $display("inv_idle: pulsed inv_i");
        model_req(1'b0, 12'h010, 64'h0, 2, "inv_idle.read");

        // Invalidate during REFILL: deferred and applied after RESP.
        run_req(1'b0, 12'h020, 64'h0, 3, 2, r);
        $display("inv_refill: addr=020 hit=%0d data=%h", r.hit, r.data);
        chk("inv_refill.ready", 64'(r.got), 64'(1));
        chk("inv_refill.hit", 64'(r.hit), 64'(0));
        chk("inv_refill.data", r.data, mem_model[11'h010]);
        model_clear();
        model_req(1'b0, 12'h020, 64'h0, 2, "inv_refill.reread");
        model_req(1'b0, 12'h010, 64'h0, 1, "inv_refill.other");

        // Reset two cycles into REFILL, then ignore a stray ack.
        dcache_req_addr = 12'h030; dcache_req_rw = 1'b0; dcache_req_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rstmid.pre_valid", 64'(mem_req_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        $display("rstmid: reset asserted in REFILL");
        chk("rstmid.mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rstmid.ready", 64'(dcache_ready), 64'(0));
        chk("rstmid.data_read", dcache_data_read, 64'h0);
        dcache_req_valid = 1'b0;
        mem_rdata = 64'hBAD0BAD0_BAD0BAD0;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("stray_ack.ready", 64'(dcache_ready), 64'(0));
        chk("stray_ack.mem_req_valid", 64'(mem_req_valid), 64'(0));
        model_clear();
        model_req(1'b0, 12'h030, 64'h0, 2, "rstmid.reread");

        // Randomized traffic over a few tags and lines to mix hits, misses and conflicts.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                inv_i = 1'b1;
                @(posedge clk); #1;
                inv_i = 1'b0;
                model_clear();
                $display("rnd%0d: inv pulse", i);
            end else begin
                ra = '0;
                ra[11:7] = 5'($urandom_range(0, 3));
                ra[3:1]  = 3'($urandom_range(0, 7));
                ra[0]    = 1'($urandom_range(0, 1));
                rrw = ($urandom_range(0, 3) == 0);
                rd  = {$urandom, $urandom};
                model_req(rrw, ra, rd, $urandom_range(1, 4), $sformatf("rnd%0d", i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
